mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum cycles mem_req waits for mem_ack.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req  input  1  fetch-stage read request, held until if_ready.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have ports if_rdata  output  DATA_W  fetched word, and if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have ports d_rd and d_wr  input  1 each  MEM-stage read and write requests, held until d_ready.
REQ-010 SHALL have ports d_addr  input  ADDR_W  and d_wdata  input  DATA_W  for data access address and write data.
REQ-011 SHALL have ports d_rdata  output  DATA_W  load data, and d_ready  output  1  one-cycle data completion pulse.
REQ-012 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W to the shared memory.
REQ-013 SHALL have ports mem_rdata  input  DATA_W  and mem_ack  input  1  from the shared memory.
REQ-014 SHALL have ports stall_if, stall_mem  output  1 each, and err  output  1  timeout pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, DATA, DONE.
REQ-016 In IDLE with only data pending (d_rd|d_wr), SHALL go to DATA; with only if_req, SHALL go to FETCH; with neither, SHALL stay in IDLE.
REQ-017 In IDLE with both pending, SHALL grant DATA unless the previous grant was DATA, in which case SHALL grant FETCH.
REQ-018 On grant, SHALL register mem_addr, mem_we, mem_wdata and assert mem_req from the next cycle, holding all four stable until completion.
REQ-019 With d_rd and d_wr both high, SHALL perform a write (mem_we=1); d_rd is ignored.
REQ-020 In FETCH or DATA, when mem_ack is sampled high, SHALL deassert mem_req, capture mem_rdata into if_rdata (FETCH) or d_rdata (DATA read), and go to DONE.
REQ-021 For DATA writes, SHALL leave d_rdata unchanged.
REQ-022 In DONE, SHALL assert exactly one of if_ready/d_ready for one cycle, ignore all requests, and return to IDLE next cycle.
REQ-023 Minimum latency: request high at edge N, mem_req high N+1, mem_ack at N+1, ready high in cycle N+2.
REQ-024 SHALL count cycles with mem_req high; if the count reaches TIMEOUT without mem_ack, SHALL drop mem_req, load 0 into the granted read-data register, pulse err with ready in DONE.
REQ-025 SHALL ignore mem_ack while in IDLE or DONE.
REQ-026 if_rdata and d_rdata SHALL hold their values until the next completion of their own type.
REQ-027 stall_if SHALL equal if_req & ~if_ready; stall_mem SHALL equal (d_rd|d_wr) & ~d_ready, combinationally.

Reset
REQ-028 On rst, SHALL go to IDLE, clear mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready, err, timeout counter, and set last-grant to FETCH.
REQ-029 rst asserted mid-transaction SHALL abort it with mem_req low from the next cycle and no ready pulse.

Structure
REQ-030 State encoding and grant enumeration SHALL reside in shared package mips_pkg.
REQ-031 Timeout counter SHALL be a sub-module named timeout_counter (clear, enable, expired).

Verification
REQ-032 if_req=1, if_addr=0x40, mem_ack one cycle after mem_req, mem_rdata=0x8C010004 -> if_ready one pulse, if_rdata=0x8C010004, stall_if high until then.
REQ-033 d_rd=1 and if_req=1 simultaneously after reset -> DATA granted first, then FETCH; second simultaneous pair after a DATA grant -> FETCH first.
REQ-034 d_wr=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF stable until mem_ack; d_rdata unchanged.
REQ-035 d_rd=1, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, then err and d_ready pulse together, d_rdata=0.
REQ-036 rst pulsed 2 cycles into a fetch -> mem_req low next cycle, no if_ready, state IDLE, outputs zero.
REQ-037 mem_ack asserted in IDLE -> no ready pulse, no register update.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared arbiter types: FSM state encoding and grant enumeration.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/timeout_counter.sv
// Counts cycles an outstanding memory request has waited.
// Ports: clk, rst (sync, active-high), clear (restart at zero),
//        enable (count this cycle), expired (this is the TIMEOUT-th waiting cycle).
module timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // Count holds cycles already waited, so it saturates one short of TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single shared memory port between instruction fetch and
// data (load/store) requests, with round-robin tie-break and a timeout.
// Ports: clk, rst (sync, active-high)
//        fetch side : if_req, if_addr -> if_rdata, if_ready
//        data side  : d_rd, d_wr, d_addr, d_wdata -> d_rdata, d_ready
//        memory     : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//        status     : stall_if, stall_mem (combinational), err (timeout pulse)
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  arbState_t         state, stateNext;
  grant_t            lastGrant, lastGrantNext;
  logic              memReqNext, memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext, ifRdataNext, dRdataNext, readData;
  logic              ifReadyNext, dReadyNext, errNext;
  logic              timeoutClear, timeoutEnable, timeoutExpired;
  logic              dataPending;

  assign dataPending = d_rd | d_wr;
  // A timed-out access returns zero in place of memory data.
  assign readData    = mem_ack ? mem_rdata : '0;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dataPending & ~d_ready;

  timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (timeoutClear),
    .enable (timeoutEnable),
    .expired(timeoutExpired)
  );

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    lastGrantNext = lastGrant;
    memReqNext    = mem_req;
    memWeNext     = mem_we;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    ifRdataNext   = if_rdata;
    dRdataNext    = d_rdata;
    ifReadyNext   = 1'b0;
    dReadyNext    = 1'b0;
    errNext       = 1'b0;
    timeoutClear  = 1'b0;
    timeoutEnable = 1'b0;

    case (state)
      IDLE: begin
        timeoutClear = 1'b1;
        // Data wins a tie unless it also won the previous grant.
        if (dataPending && (!if_req || lastGrant == GRANT_FETCH)) begin
          stateNext     = DATA;
          lastGrantNext = GRANT_DATA;
          memReqNext    = 1'b1;
          memWeNext     = d_wr;
          memAddrNext   = d_addr;
          memWdataNext  = d_wdata;
        end else if (if_req) begin
          stateNext     = FETCH;
          lastGrantNext = GRANT_FETCH;
          memReqNext    = 1'b1;
          memWeNext     = 1'b0;
          memAddrNext   = if_addr;
          memWdataNext  = '0;
        end
      end

      FETCH, DATA: begin
        timeoutEnable = 1'b1;
        if (mem_ack || timeoutExpired) begin
          stateNext  = DONE;
          memReqNext = 1'b0;
          errNext    = ~mem_ack;
          if (state == FETCH) begin
            ifReadyNext = 1'b1;
            ifRdataNext = readData;
          end else begin
            dReadyNext = 1'b1;
            if (!mem_we) begin
              dRdataNext = readData;
            end
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= GRANT_FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      if_rdata  <= ifRdataNext;
      d_rdata   <= dRdataNext;
      if_ready  <= ifReadyNext;
      d_ready   <= dReadyNext;
      err       <= errNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_rd, d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall_if, stall_mem, err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .err      (err)
  );

  // Transaction-level model: one outstanding access, its age, and a ready cycle.
  bit          mBusy, mDone, mIsData, mWe, mLastData, mInReset;
  bit          mMemReq, mIfReady, mDReady, mErr;
  logic [31:0] mAddr, mWdata, mIfRdata, mDRdata;
  int          mAge;
  int          nVec, nFail, cycle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    logic [31:0] got;
    mIfReady = 1'b0;
    mDReady  = 1'b0;
    mErr     = 1'b0;
    mInReset = 1'b0;
    if (rst) begin
      mBusy = 0; mDone = 0; mMemReq = 0; mWe = 0; mLastData = 0; mInReset = 1;
      mAddr = '0; mWdata = '0; mIfRdata = '0; mDRdata = '0; mAge = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (mBusy) begin
      mAge++;
      if (mem_ack || mAge == int'(TIMEOUT)) begin
        got     = mem_ack ? mem_rdata : 32'h0;
        mErr    = !mem_ack;
        mBusy   = 0;
        mMemReq = 0;
        mDone   = 1;
        if (mIsData) begin
          mDReady = 1;
          if (!mWe) mDRdata = got;
        end else begin
          mIfReady = 1;
          mIfRdata = got;
        end
      end
    end else begin
      if ((d_rd || d_wr) && !(if_req && mLastData)) begin
        mIsData = 1; mWe = d_wr; mAddr = d_addr; mWdata = d_wdata;
        mBusy = 1;
      end else if (if_req) begin
        mIsData = 0; mWe = 0; mAddr = if_addr;
        mBusy = 1;
      end
      if (mBusy) begin
        mMemReq   = 1;
        mAge      = 0;
        mLastData = mIsData;
      end
    end
  endtask

  task automatic compareAll();
    chk("mem_req",   mem_req,   mMemReq);
    chk("if_ready",  if_ready,  mIfReady);
    chk("d_ready",   d_ready,   mDReady);
    chk("err",       err,       mErr);
    chk("if_rdata",  if_rdata,  mIfRdata);
    chk("d_rdata",   d_rdata,   mDRdata);
    chk("stall_if",  stall_if,  if_req & ~mIfReady);
    chk("stall_mem", stall_mem, (d_rd | d_wr) & ~mDReady);
    if (mMemReq || mInReset) begin
      chk("mem_addr", mem_addr, mAddr);
      chk("mem_we",   mem_we,   mWe);
    end
    if ((mMemReq && mWe) || mInReset) begin
      chk("mem_wdata", mem_wdata, mWdata);
    end
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    cycle++;
    compareAll();
  endtask

  initial begin
    int highs;
    int kind;
    nVec = 0; nFail = 0; cycle = 0;
    mBusy = 0; mDone = 0; mIsData = 0; mWe = 0; mLastData = 0; mInReset = 0;
    mMemReq = 0; mIfReady = 0; mDReady = 0; mErr = 0; mAge = 0;
    mAddr = '0; mWdata = '0; mIfRdata = '0; mDRdata = '0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    step(); step();
    chk("rst_mem_req",  mem_req,  0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata",  d_rdata,  0);
    chk("rst_err",      err,      0);
    rst = 1'b0;

    // Single fetch, memory acks one cycle after the request.
    if_req = 1; if_addr = 32'h40;
    step();
    chk("f_req",   mem_req,  1);
    chk("f_addr",  mem_addr, 32'h40);
    chk("f_stall", stall_if, 1);
    mem_ack = 1; mem_rdata = 32'h8C010004;
    step();
    chk("f_ready", if_ready, 1);
    chk("f_rdata", if_rdata, 32'h8C010004);
    chk("f_reqlo", mem_req,  0);
    if_req = 0; mem_ack = 0;
    step();
    chk("f_pulse", if_ready, 0);

    // Tie after a fetch grant: data first, then fetch.
    d_rd = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h44;
    step();
    chk("t1_first", mem_addr, 32'h200);
    mem_ack = 1; mem_rdata = 32'h11111111;
    step();
    chk("t1_dready", d_ready, 1);
    chk("t1_drdata", d_rdata, 32'h11111111);
    d_rd = 0; mem_ack = 0;
    step(); step();
    chk("t1_second", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'h22222222;
    step();
    chk("t1_iready", if_ready, 1);
    if_req = 0; mem_ack = 0;
    step();

    // Store: address/data/we held until ack, load data untouched.
    d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w_we",    mem_we,    1);
      chk("w_addr",  mem_addr,  32'h100);
      chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    end
    mem_ack = 1; mem_rdata = 32'h33333333;
    step();
    chk("w_ready", d_ready, 1);
    chk("w_keep",  d_rdata, 32'h11111111);
    d_wr = 0; mem_ack = 0;
    step();

    // Tie after a data grant: fetch first.
    d_rd = 1; d_addr = 32'h204; if_req = 1; if_addr = 32'h48;
    step();
    chk("t2_first", mem_addr, 32'h48);
    mem_ack = 1; mem_rdata = 32'h44444444;
    step();
    chk("t2_iready", if_ready, 1);
    if_req = 0; mem_ack = 0;
    step(); step();
    chk("t2_second", mem_addr, 32'h204);
    mem_ack = 1; mem_rdata = 32'h55555555;
    step();
    chk("t2_drdata", d_rdata, 32'h55555555);
    d_rd = 0; mem_ack = 0;
    step();

    // Load that is never acknowledged.
    d_rd = 1; d_addr = 32'h300;
    step();
    highs = int'(mem_req);
    for (int i = 0; i < 15; i++) begin
      step();
      highs += int'(mem_req);
    end
    step();
    chk("to_cycles", highs,   16);
    chk("to_err",    err,     1);
    chk("to_ready",  d_ready, 1);
    chk("to_reqlo",  mem_req, 0);
    chk("to_rdata",  d_rdata, 0);
    d_rd = 0;
    step();

    // Stray ack while idle.
    mem_ack = 1; mem_rdata = 32'h66666666;
    step(); step();
    chk("ia_ready",  if_ready | d_ready, 0);
    chk("ia_ifdata", if_rdata, 32'h44444444);
    chk("ia_ddata",  d_rdata,  0);
    mem_ack = 0;

    // Reset two cycles into a fetch.
    if_req = 1; if_addr = 32'h80;
    step(); step();
    rst = 1;
    step();
    chk("r_req",    mem_req,  0);
    chk("r_ready",  if_ready, 0);
    chk("r_ifdata", if_rdata, 0);
    chk("r_addr",   mem_addr, 0);
    rst = 0; if_req = 0;
    step();
    chk("r_noready", if_ready, 0);

    // Randomized traffic; periodic windows where memory never acks.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (!(d_rd || d_wr) && $urandom_range(0, 3) == 0) begin
        kind    = int'($urandom_range(0, 2));
        d_rd    = (kind != 1);
        d_wr    = (kind != 0);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_ack   = (((i / 150) % 4) == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      step();
      if (mIfReady) if_req = 0;
      if (mDReady) begin
        d_rd = 0; d_wr = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
